// File: rtl/regfile_arbiter.sv
// Two-port round-robin sequencer for the 4-entry register file: latches one
// READ/WRITE/COPY command at a time and drives the file's op, selects and data.
module regfile_arbiter #(
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_a,
  input  logic                      req_b,
  input  logic [1:0]                cmd_a,
  input  logic [1:0]                cmd_b,
  input  logic [1:0]                dst_a,
  input  logic [1:0]                dst_b,
  input  logic [1:0]                src_a,
  input  logic [1:0]                src_b,
  input  logic [DATA_BUS_WIDTH-1:0] wdata_a,
  input  logic [DATA_BUS_WIDTH-1:0] wdata_b,
  output logic                      ack_a,
  output logic                      ack_b,
  output logic                      err,
  output logic [DATA_BUS_WIDTH-1:0] rdata_1,
  output logic [DATA_BUS_WIDTH-1:0] rdata_2,
  output logic                      busy,
  output logic [1:0]                rf_op,
  output logic [1:0]                rf_sel_1,
  output logic [1:0]                rf_sel_2,
  output logic [DATA_BUS_WIDTH-1:0] rf_wdata,
  input  logic [DATA_BUS_WIDTH-1:0] rf_rd_1,
  input  logic [DATA_BUS_WIDTH-1:0] rf_rd_2
);

  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_COPY  = 2'b10;
  localparam logic [1:0] CMD_RSVD  = 2'b11;
  localparam logic [1:0] REG_NOP   = 2'b00;
  localparam logic [1:0] REG_WRITE = 2'b01;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXEC_RD = 3'd1,
    EXEC_WR = 3'd2,
    COPY_RD = 3'd3,
    COPY_WR = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e state_reg, state_next;

  // Port identifiers in last_reg / win_reg: 0 = A, 1 = B.
  logic                      last_reg;
  logic                      win_reg;
  logic [1:0]                cmd_reg;
  logic [1:0]                dst_reg;
  logic [1:0]                src_reg;
  logic [DATA_BUS_WIDTH-1:0] wdata_reg;
  logic [DATA_BUS_WIDTH-1:0] tmp_reg;
  logic [DATA_BUS_WIDTH-1:0] rdata_1_reg;
  logic [DATA_BUS_WIDTH-1:0] rdata_2_reg;

  logic                      accept;
  logic                      grant_b;
  logic [1:0]                cmd_win;
  logic [1:0]                dst_win;
  logic [1:0]                src_win;
  logic [DATA_BUS_WIDTH-1:0] wdata_win;

  // B wins when it is the only requester, or when both request and A was served last.
  always_comb begin
    accept    = (state_reg == IDLE) && (req_a || req_b);
    grant_b   = req_b && (!req_a || !last_reg);
    cmd_win   = grant_b ? cmd_b   : cmd_a;
    dst_win   = grant_b ? dst_b   : dst_a;
    src_win   = grant_b ? src_b   : src_a;
    wdata_win = grant_b ? wdata_b : wdata_a;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (cmd_win)
            CMD_READ:  state_next = EXEC_RD;
            CMD_WRITE: state_next = EXEC_WR;
            CMD_COPY:  state_next = COPY_RD;
            default:   state_next = DONE;
          endcase
        end
      end
      EXEC_RD: state_next = DONE;
      EXEC_WR: state_next = DONE;
      COPY_RD: state_next = COPY_WR;
      COPY_WR: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      last_reg    <= 1'b1;
      win_reg     <= 1'b0;
      cmd_reg     <= CMD_READ;
      dst_reg     <= '0;
      src_reg     <= '0;
      wdata_reg   <= '0;
      tmp_reg     <= '0;
      rdata_1_reg <= '0;
      rdata_2_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        last_reg  <= grant_b;
        win_reg   <= grant_b;
        cmd_reg   <= cmd_win;
        dst_reg   <= dst_win;
        src_reg   <= src_win;
        wdata_reg <= wdata_win;
      end
      if (state_reg == EXEC_RD) begin
        rdata_1_reg <= rf_rd_1;
        rdata_2_reg <= rf_rd_2;
      end
      if (state_reg == COPY_RD) begin
        tmp_reg <= rf_rd_2;
      end
    end
  end

  always_comb begin
    rf_op    = REG_NOP;
    rf_sel_1 = '0;
    rf_sel_2 = '0;
    rf_wdata = '0;
    case (state_reg)
      EXEC_RD: begin
        rf_sel_1 = dst_reg;
        rf_sel_2 = src_reg;
      end
      EXEC_WR: begin
        rf_sel_1 = dst_reg;
        rf_wdata = wdata_reg;
        rf_op    = REG_WRITE;
      end
      COPY_RD: begin
        rf_sel_2 = src_reg;
      end
      COPY_WR: begin
        rf_sel_1 = dst_reg;
        rf_wdata = tmp_reg;
        rf_op    = REG_WRITE;
      end
      default: begin
      end
    endcase
  end

  assign ack_a   = (state_reg == DONE) && !win_reg;
  assign ack_b   = (state_reg == DONE) && win_reg;
  assign err     = (state_reg == DONE) && (cmd_reg == CMD_RSVD);
  assign busy    = (state_reg != IDLE);
  assign rdata_1 = rdata_1_reg;
  assign rdata_2 = rdata_2_reg;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: emulates the register file, runs a directed vector
// table, arbitration/reset sequences and random commands against a command-level model.
module tb_regfile_arbiter;

  localparam logic [1:0] REG_WRITE = 2'b01;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [1:0] cmd_a = '0, cmd_b = '0, dst_a = '0, dst_b = '0, src_a = '0, src_b = '0;
  logic [7:0] wdata_a = '0, wdata_b = '0;
  logic       ack_a, ack_b, err, busy;
  logic [7:0] rdata_1, rdata_2, rf_wdata, rf_rd_1, rf_rd_2;
  logic [1:0] rf_op, rf_sel_1, rf_sel_2;

  regfile_arbiter #(.DATA_BUS_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .req_b(req_b), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .dst_a(dst_a), .dst_b(dst_b), .src_a(src_a), .src_b(src_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .err(err),
    .rdata_1(rdata_1), .rdata_2(rdata_2), .busy(busy),
    .rf_op(rf_op), .rf_sel_1(rf_sel_1), .rf_sel_2(rf_sel_2), .rf_wdata(rf_wdata),
    .rf_rd_1(rf_rd_1), .rf_rd_2(rf_rd_2)
  );

  always #5 clock = ~clock;

  // Register file stand-in: writes land on the falling edge, reads are combinational.
  logic [7:0] rf_mem [4] = '{default: 8'h00};
  always @(negedge clock) if (rf_op == REG_WRITE) rf_mem[rf_sel_1] <= rf_wdata;
  assign rf_rd_1 = rf_mem[rf_sel_1];
  assign rf_rd_2 = rf_mem[rf_sel_2];

  int cyc = 0, wr_cnt = 0, both_cnt = 0, ack_cnt = 0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (rf_op == REG_WRITE) wr_cnt <= wr_cnt + 1;
  always @(negedge clock) if (ack_a && ack_b) both_cnt <= both_cnt + 1;
  always @(negedge clock) if (ack_a || ack_b) ack_cnt <= ack_cnt + 1;

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Command-level reference: register contents, last READ results, last served port.
  logic [7:0] m_regs [4] = '{default: 8'h00};
  logic [7:0] m_r1 = 8'h00, m_r2 = 8'h00;
  bit         m_last = 1'b1;

  task automatic model_exec(input bit port, input logic [1:0] cmd, input logic [1:0] d,
                            input logic [1:0] s, input logic [7:0] w,
                            output int lat, output logic e, output int wrs);
    e = 1'b0; wrs = 0; lat = 2;
    case (cmd)
      2'd0: begin m_r1 = m_regs[d]; m_r2 = m_regs[s]; end
      2'd1: begin m_regs[d] = w; wrs = 1; end
      2'd2: begin m_regs[d] = m_regs[s]; wrs = 1; lat = 3; end
      default: begin lat = 1; e = 1'b1; end
    endcase
    m_last = port;
  endtask

  task automatic drive(input bit port, input logic r, input logic [1:0] c, input logic [1:0] d,
                       input logic [1:0] s, input logic [7:0] w);
    if (!port) begin req_a = r; cmd_a = c; dst_a = d; src_a = s; wdata_a = w; end
    else       begin req_b = r; cmd_b = c; dst_b = d; src_b = s; wdata_b = w; end
  endtask

  // Issue one command, scramble its fields after acceptance, wait (bounded) for the ack.
  task automatic run_cmd(input bit port, input logic [1:0] cmd, input logic [1:0] d,
                         input logic [1:0] s, input logic [7:0] w,
                         output int lat, output logic e, output logic [7:0] r1,
                         output logic [7:0] r2, output int wrs);
    int c0, w0;
    bit got;
    @(negedge clock);
    drive(port, 1'b1, cmd, d, s, w);
    c0 = cyc; w0 = wr_cnt; got = 1'b0;
    lat = -1; e = 1'b0; r1 = '0; r2 = '0; wrs = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clock);
      if ((!port && ack_a) || (port && ack_b)) begin
        got = 1'b1; lat = cyc - c0; e = err; r1 = rdata_1; r2 = rdata_2; wrs = wr_cnt - w0;
        drive(port, 1'b0, 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
      end else begin
        drive(port, 1'b1, 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
      end
    end
    if (!got) drive(port, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0);
    check($sformatf("ack_seen p%0d cmd%0d", port, cmd), 32'(got), 32'd1);
  endtask

  task automatic run_and_check(input string tag, input bit port, input logic [1:0] cmd,
                               input logic [1:0] d, input logic [1:0] s, input logic [7:0] w);
    int el, ew, al, aw;
    logic ee, ae;
    logic [7:0] a1, a2;
    model_exec(port, cmd, d, s, w, el, ee, ew);
    run_cmd(port, cmd, d, s, w, al, ae, a1, a2, aw);
    $display("%s: port=%0d cmd=%0d dst=%0d src=%0d wdata=%02h lat=%0d err=%0d rdata=%02h/%02h",
             tag, port, cmd, d, s, w, al, ae, a1, a2);
    check({tag, "_lat"}, 32'(al), 32'(el));
    check({tag, "_err"}, 32'(ae), 32'(ee));
    check({tag, "_rdata_1"}, 32'(a1), 32'(m_r1));
    check({tag, "_rdata_2"}, 32'(a2), 32'(m_r2));
    check({tag, "_writes"}, 32'(aw), 32'(ew));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ack_a"}, 32'(ack_a), 32'd0);
    check({tag, "_ack_b"}, 32'(ack_b), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_op_is_write"}, 32'(rf_op == REG_WRITE), 32'd0);
    check({tag, "_sel_1"}, 32'(rf_sel_1), 32'd0);
    check({tag, "_sel_2"}, 32'(rf_sel_2), 32'd0);
    check({tag, "_wdata"}, 32'(rf_wdata), 32'd0);
    check({tag, "_rdata_1"}, 32'(rdata_1), 32'd0);
    check({tag, "_rdata_2"}, 32'(rdata_2), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0);
    drive(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0);
    m_r1 = 8'h00; m_r2 = 8'h00; m_last = 1'b1;
    #1 check_idle_outputs("reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    bit         port;
    logic [1:0] cmd, dst, src;
    logic [7:0] wd;
    int         lat;
    logic       e;
    logic [7:0] r1, r2;
    int         wrs;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int ml, mw, al, aw, c0, ta, tbk, n;
    logic me, ae;
    logic [7:0] a1, a2, last_r1, last_r2;
    bit ports [4];
    int times [4];
    bit first;

    //          port cmd   dst   src   wdata  lat err  rdata_1 rdata_2 writes
    tbl[0] = '{1'b0, 2'd1, 2'd2, 2'd0, 8'h5A, 2, 1'b0, 8'h00, 8'h00, 1};
    tbl[1] = '{1'b0, 2'd0, 2'd2, 2'd0, 8'h00, 2, 1'b0, 8'h5A, 8'h00, 0};
    tbl[2] = '{1'b0, 2'd1, 2'd3, 2'd0, 8'hC3, 2, 1'b0, 8'h5A, 8'h00, 1};
    tbl[3] = '{1'b1, 2'd2, 2'd0, 2'd3, 8'h00, 3, 1'b0, 8'h5A, 8'h00, 1};
    tbl[4] = '{1'b0, 2'd0, 2'd0, 2'd3, 8'h00, 2, 1'b0, 8'hC3, 8'hC3, 0};
    tbl[5] = '{1'b1, 2'd2, 2'd3, 2'd3, 8'h00, 3, 1'b0, 8'hC3, 8'hC3, 1};
    tbl[6] = '{1'b1, 2'd0, 2'd3, 2'd2, 8'h00, 2, 1'b0, 8'hC3, 8'h5A, 0};
    tbl[7] = '{1'b0, 2'd3, 2'd1, 2'd2, 8'hFF, 1, 1'b1, 8'hC3, 8'h5A, 0};
    tbl[8] = '{1'b0, 2'd0, 2'd1, 2'd0, 8'h00, 2, 1'b0, 8'h00, 8'hC3, 0};

    #1 reset = 1'b0;
    #1 check_idle_outputs("por");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      model_exec(tbl[i].port, tbl[i].cmd, tbl[i].dst, tbl[i].src, tbl[i].wd, ml, me, mw);
      run_cmd(tbl[i].port, tbl[i].cmd, tbl[i].dst, tbl[i].src, tbl[i].wd, al, ae, a1, a2, aw);
      $display("vec%0d: port=%0d cmd=%0d lat=%0d err=%0d rdata=%02h/%02h writes=%0d",
               i, tbl[i].port, tbl[i].cmd, al, ae, a1, a2, aw);
      check($sformatf("vec%0d_lat", i), 32'(al), 32'(tbl[i].lat));
      check($sformatf("vec%0d_err", i), 32'(ae), 32'(tbl[i].e));
      check($sformatf("vec%0d_rdata_1", i), 32'(a1), 32'(tbl[i].r1));
      check($sformatf("vec%0d_rdata_2", i), 32'(a2), 32'(tbl[i].r2));
      check($sformatf("vec%0d_writes", i), 32'(aw), 32'(tbl[i].wrs));
    end

    // Simultaneous requests straight after reset: A first, B three cycles later.
    do_reset();
    @(negedge clock);
    drive(1'b0, 1'b1, 2'd1, 2'd1, 2'd0, 8'h11);
    drive(1'b1, 1'b1, 2'd1, 2'd1, 2'd0, 8'h22);
    c0 = cyc; ta = -1; tbk = -1;
    for (int i = 0; i < 12 && (ta < 0 || tbk < 0); i++) begin
      @(negedge clock);
      if (ack_a && ta < 0) begin ta = cyc - c0; drive(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0); end
      if (ack_b && tbk < 0) begin tbk = cyc - c0; drive(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0); end
    end
    drive(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0);
    drive(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0);
    $display("simul: ack_a at +%0d, ack_b at +%0d", ta, tbk);
    check("simul_ack_a_lat", 32'(ta), 32'd2);
    check("simul_ack_b_lat", 32'(tbk), 32'd5);
    model_exec(1'b0, 2'd1, 2'd1, 2'd0, 8'h11, ml, me, mw);
    model_exec(1'b1, 2'd1, 2'd1, 2'd0, 8'h22, ml, me, mw);
    run_and_check("simul_readback", 1'b0, 2'd0, 2'd1, 2'd1, 8'h00);

    // Both ports hold READ: grants alternate, three cycles apart.
    first = !m_last;
    @(negedge clock);
    drive(1'b0, 1'b1, 2'd0, 2'd1, 2'd2, 8'h00);
    drive(1'b1, 1'b1, 2'd0, 2'd3, 2'd0, 8'h00);
    n = 0; last_r1 = '0; last_r2 = '0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clock);
      if (ack_a || ack_b) begin
        ports[n] = ack_b; times[n] = cyc; n++;
        if (n == 4) begin
          last_r1 = rdata_1; last_r2 = rdata_2;
          drive(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0);
          drive(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0);
        end
      end
    end
    drive(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0);
    drive(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0);
    check("alt_ack_count", 32'(n), 32'd4);
    for (int i = 0; i < n; i++) begin
      $display("alt: ack %0d from port %0d at cycle %0d", i, ports[i], times[i]);
      check($sformatf("alt%0d_port", i), 32'(ports[i]), 32'(first ^ bit'(i & 1)));
      if (i > 0) check($sformatf("alt%0d_gap", i), 32'(times[i] - times[i-1]), 32'd3);
    end
    for (int i = 0; i < 4; i++) begin
      if ((first ^ bit'(i & 1)) == 1'b0) model_exec(1'b0, 2'd0, 2'd1, 2'd2, 8'h00, ml, me, mw);
      else                               model_exec(1'b1, 2'd0, 2'd3, 2'd0, 8'h00, ml, me, mw);
    end
    check("alt_rdata_1", 32'(last_r1), 32'(m_r1));
    check("alt_rdata_2", 32'(last_r2), 32'(m_r2));

    // Reset during COPY_RD drops the command and leaves the destination alone.
    run_and_check("pre_copy_r0", 1'b0, 2'd1, 2'd0, 2'd0, 8'h00);
    run_and_check("pre_copy_r3", 1'b0, 2'd1, 2'd3, 2'd0, 8'hC3);
    @(negedge clock);
    drive(1'b0, 1'b1, 2'd2, 2'd0, 2'd3, 8'h00);
    @(negedge clock);
    check("copy_rd_busy", 32'(busy), 32'd1);
    check("copy_rd_sel_2", 32'(rf_sel_2), 32'd3);
    c0 = ack_cnt;
    reset = 1'b0;
    #1 check_idle_outputs("midcopy_reset");
    drive(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'd0);
    m_r1 = 8'h00; m_r2 = 8'h00; m_last = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("midcopy_no_ack", 32'(ack_cnt - c0), 32'd0);
    run_and_check("post_reset_read", 1'b0, 2'd0, 2'd0, 2'd3, 8'h00);

    for (int i = 0; i < 40; i++) begin
      run_and_check($sformatf("rnd%0d", i), 1'($urandom), 2'($urandom_range(0, 3)),
                    2'($urandom), 2'($urandom), 8'($urandom));
    end

    check("never_both_acks", 32'(both_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Sequencer and two-port arbiter for the 4-entry `registers` file. It accepts read, write and copy commands from two requesters (A: core datapath, B: debug/load port), grants them round-robin, and drives the register file's `op`, select and write-data inputs. It returns read data with a one-cycle acknowledge. It sits between the requesters and the register file; only this block drives the register file's inputs.

## Interface
- `DATA_BUS_WIDTH`, 8, width of register data.
- `clock`  in  1  system clock; this block is rising-edge clocked.
- `reset`  in  1  asynchronous, active-low reset.
- `req_a` / `req_b`  in  1  command request, held until the matching ack.
- `cmd_a` / `cmd_b`  in  2  command: 00 READ, 01 WRITE, 10 COPY, 11 reserved.
- `dst_a` / `dst_b`  in  register_sel_e  READ port-1 select, WRITE target, COPY destination.
- `src_a` / `src_b`  in  register_sel_e  READ port-2 select, COPY source.
- `wdata_a` / `wdata_b`  in  DATA_BUS_WIDTH  WRITE data.
- `ack_a` / `ack_b`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with ack; 1 = reserved command, no register access performed.
- `rdata_1` / `rdata_2`  out  DATA_BUS_WIDTH  READ results, valid with ack and held until the next READ completes.
- `busy`  out  1  state != IDLE.
- `rf_op`  out  registers_op_e  REG_WRITE only in write phases; any non-REG_WRITE value otherwise.
- `rf_sel_1` / `rf_sel_2`  out  register_sel_e  drive the register file's `reg_1_out_sel` / `reg_2_out_sel`.
- `rf_wdata`  out  DATA_BUS_WIDTH  drives `reg_data_in`.
- `rf_rd_1` / `rf_rd_2`  in  DATA_BUS_WIDTH  from the register file's `reg_1_out` / `reg_2_out`.

## Operation
- FSM states and transitions:
  - IDLE → EXEC_RD, EXEC_WR or COPY_RD according to the latched command.
  - A reserved command goes IDLE → DONE directly.
  - EXEC_RD → DONE. EXEC_WR → DONE. COPY_RD → COPY_WR → DONE.
  - DONE → IDLE.
- Acceptance:
  - In IDLE, a sampled `req_x` is accepted at the rising edge.
  - The winner's cmd, dst, src and wdata are latched, and the winner ID is recorded.
  - Requester fields are ignored after the acceptance edge.
- Arbitration: round-robin. The `last` flop records the most recently accepted port.
  - Reset value of `last` is B, so A wins first.
  - If both requests are high, the port != `last` wins.
  - A single request wins unconditionally.
- Phase outputs (all decoded from registered state and latched command; no combinational path from `req`):
  - EXEC_RD: `rf_sel_1`=dst, `rf_sel_2`=src. `rdata_1`/`rdata_2` capture `rf_rd_1`/`rf_rd_2` at the closing edge.
  - EXEC_WR: `rf_sel_1`=dst, `rf_wdata`=wdata, `rf_op`=REG_WRITE.
  - COPY_RD: `rf_sel_2`=src. Capture `rf_rd_2` into `tmp` at the closing edge.
  - COPY_WR: `rf_sel_1`=dst, `rf_wdata`=tmp, `rf_op`=REG_WRITE.
  - DONE: pulse `ack` of the recorded winner; `err` = (cmd==11).
  - In all other states: sels=0, `rf_wdata`=0, `rf_op` != REG_WRITE.
- COPY with src==dst is legal; the value is unchanged.
- The losing requester keeps `req` high and is served next. There is no starvation: at most one foreign command runs between two of its own.

## Timing
- Request first sampled high in IDLE at the edge closing cycle N.
- READ/WRITE: EXEC in N+1, `ack` in N+2. COPY: COPY_RD N+1, COPY_WR N+2, `ack` N+3. Reserved command: `ack`+`err` in N+1.
- The register file commits writes on the falling edge inside the write-phase cycle. Data written is visible on `rf_rd_*` by the next rising edge.
- The requester deasserts `req` in the cycle after `ack`. Any `req` sampled high in IDLE is a new command.
- Throughput: one READ/WRITE per 3 cycles, one COPY per 4 cycles. A back-to-back grant to the other port starts in the IDLE after DONE.
- Reset (asynchronous, any cycle, including mid-COPY):
  - Immediately: state=IDLE, `last`=B, `ack_a`=`ack_b`=`err`=`busy`=0, `rdata_*`=0, `tmp`=0, `rf_op` != REG_WRITE, sels=0, `rf_wdata`=0.
  - An interrupted command is dropped without ack. A COPY interrupted before COPY_WR leaves the destination unmodified.

## Test plan
- Reset, then A WRITE dst=2 wdata=0x5A, then A READ dst=2 src=0 → `ack_a` in N+2, `rdata_1`=0x5A, `rdata_2`=0x00; `rf_op`=REG_WRITE for exactly one cycle.
- `req_a` and `req_b` rise together (A WRITE r1=0x11, B WRITE r1=0x22) → A acked first, B acked 3 cycles later; final r1=0x22; no cycle with both acks high.
- A and B both hold READ continuously for 12 cycles → acks alternate A, B, A, B, each 3 cycles apart.
- r3=0xC3; B COPY src=3 dst=0 → `ack_b` in N+3, then READ r0 = 0xC3; COPY src=dst=3 leaves r3 = 0xC3.
- A cmd=11 → `ack_a`+`err` in N+1, no REG_WRITE cycle, registers unchanged.
- Reset asserted during COPY_RD (COPY r3→r0, r0=0x00) → outputs zero at once, no ack; r0 is still 0 after release; the next A READ is served normally.
